// File: rtl/reg_bank_pkg.sv
// Shared encodings and helpers for the multi-port register bank.
// Covers the write-source and half-word encodings, the write FSM states and selector validation.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    IP_NONE  = 3'b000,
    IP_RTR   = 3'b001,
    IP_ALU   = 3'b010,
    IP_DIB   = 3'b011,
    IP_IMM_Z = 3'b100,
    IP_IMM_S = 3'b101
  } ip_sel_e;

  typedef enum logic [1:0] {
    HL_FULL = 2'b00,
    HL_LOW  = 2'b01,
    HL_HIGH = 2'b10
  } hl_sel_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACK,
    WR_WAIT_LOW
  } wr_state_e;

  // A selector names a register only when its MSB is clear and it is in range.
  function automatic logic sel_valid(input logic [31:0] sel,
                                     input int unsigned sel_w,
                                     input int unsigned num_regs);
    return !sel[5'(sel_w - 1)] && (sel < num_regs);
  endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Bus between the decoder/control side (master) and the register bank (slave).
interface reg_bank_mp_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int IMM_W  = 16
);
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] dib;
  logic [IMM_W-1:0]  id_imme;
  logic [SEL_W-1:0]  alu_a_sel;
  logic [SEL_W-1:0]  alu_b_sel;
  logic [SEL_W-1:0]  addr_sel;
  logic [SEL_W-1:0]  dob_sel;
  logic [SEL_W-1:0]  rtr_sel;
  logic [1:0]        hl_sel;
  logic [2:0]        ip_sel;
  logic [SEL_W-1:0]  ip_reg_sel;
  logic [SEL_W-1:0]  reg_clr_sel;
  logic              reg_wr;
  logic              reg_clr;
  logic              pc_incr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] addr_out;
  logic [DATA_W-1:0] dob;
  logic              reg_wr_ack;

  modport master (
    output alu_out, dib, id_imme, alu_a_sel, alu_b_sel, addr_sel, dob_sel,
           rtr_sel, hl_sel, ip_sel, ip_reg_sel, reg_clr_sel, reg_wr, reg_clr, pc_incr,
    input  alu_a, alu_b, addr_out, dob, reg_wr_ack
  );

  modport slave (
    input  alu_out, dib, id_imme, alu_a_sel, alu_b_sel, addr_sel, dob_sel,
           rtr_sel, hl_sel, ip_sel, ip_reg_sel, reg_clr_sel, reg_wr, reg_clr, pc_incr,
    output alu_a, alu_b, addr_out, dob, reg_wr_ack
  );
endinterface

// File: rtl/reg_bank_wr_ctrl.sv
// Write request/acknowledge handshake: one commit per request, Moore ack one cycle later.
module reg_bank_wr_ctrl
  import reg_bank_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic reg_wr,
  output logic wr_commit,
  output logic reg_wr_ack
);

  wr_state_e state_q, state_d;
  logic      ack_q, ack_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE:     if (reg_wr)  state_d = WR_ACK;
      WR_ACK:      state_d = reg_wr ? WR_WAIT_LOW : WR_IDLE;
      WR_WAIT_LOW: if (!reg_wr) state_d = WR_IDLE;
      default:     state_d = WR_IDLE;
    endcase
    ack_d = (state_d == WR_ACK);
  end

  // The commit is taken only from IDLE; a held request cannot write twice.
  assign wr_commit  = (state_q == WR_IDLE) && reg_wr;
  assign reg_wr_ack = ack_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= WR_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Parametrised register bank: four combinational read ports, muxed/half-word write path,
// single-register clear and PC auto-increment.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS) + 1,
  parameter int IMM_W    = 16,
  parameter int PC_IDX   = NUM_REGS - 1,
  parameter int PC_STEP  = 4,
  parameter int BYPASS   = 0
) (
  input logic          clk,
  input logic          rst_b,
  reg_bank_mp_if.slave bus
);

  localparam int IDX_W = SEL_W - 1;
  localparam int H     = DATA_W / 2;

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_arr_t;

  reg_arr_t          regs_q, regs_d, rd_arr;
  logic              wr_commit;
  logic              src_en;
  logic [DATA_W-1:0] src, cur, merged;
  logic [IDX_W-1:0]  wr_idx;

  reg_bank_wr_ctrl u_wr_ctrl (
    .clk        (clk),
    .rst_b      (rst_b),
    .reg_wr     (bus.reg_wr),
    .wr_commit  (wr_commit),
    .reg_wr_ack (bus.reg_wr_ack)
  );

  function automatic logic [DATA_W-1:0] rd_port(input reg_arr_t arr, input logic [SEL_W-1:0] sel);
    if (sel_valid(32'(sel), SEL_W, NUM_REGS)) return arr[sel[IDX_W-1:0]];
    return '0;
  endfunction

  always_comb begin
    src_en = 1'b1;
    src    = '0;
    case (bus.ip_sel)
      IP_RTR:   src = rd_port(regs_q, bus.rtr_sel);
      IP_ALU:   src = bus.alu_out;
      IP_DIB:   src = bus.dib;
      IP_IMM_Z: src = DATA_W'(bus.id_imme);
      IP_IMM_S: src = DATA_W'($signed(bus.id_imme));
      default:  src_en = 1'b0;
    endcase

    // Half-word modes always take the low half of the source.
    wr_idx = bus.ip_reg_sel[IDX_W-1:0];
    cur    = regs_q[wr_idx];
    case (bus.hl_sel)
      HL_LOW:  merged = {cur[DATA_W-1:H], src[H-1:0]};
      HL_HIGH: merged = {src[H-1:0], cur[H-1:0]};
      default: merged = src;
    endcase

    // Later assignments override earlier ones: clear > write > pc_incr.
    regs_d = regs_q;
    if (bus.pc_incr)
      regs_d[IDX_W'(PC_IDX)] = regs_q[IDX_W'(PC_IDX)] + DATA_W'(PC_STEP);
    if (wr_commit && src_en && sel_valid(32'(bus.ip_reg_sel), SEL_W, NUM_REGS))
      regs_d[wr_idx] = merged;
    if (bus.reg_clr && sel_valid(32'(bus.reg_clr_sel), SEL_W, NUM_REGS))
      regs_d[bus.reg_clr_sel[IDX_W-1:0]] = '0;
  end

  // NOTE: the array is built from flops, not RAM, so it can and must be reset to all zeros.
  always_ff @(posedge clk) begin
    if (!rst_b) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rd_arr       = (BYPASS != 0) ? regs_d : regs_q;
  assign bus.alu_a    = rd_port(rd_arr, bus.alu_a_sel);
  assign bus.alu_b    = rd_port(rd_arr, bus.alu_b_sel);
  assign bus.addr_out = rd_port(rd_arr, bus.addr_sel);
  assign bus.dob      = rd_port(rd_arr, bus.dob_sel);

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-port general-purpose register bank for the core datapath. Next generation of the fixed 32-bit bank:
- generic width and depth
- four combinational read ports (ALU A/B, address, data-out)
- selectable write source, with half-word and sign/zero-extended immediate modes
- PC auto-increment and single-register clear
- a real write request/acknowledge handshake FSM that guarantees exactly one write per request

Sits between the instruction decoder/control unit and the ALU and memory interface.

Parameters:
DATA_W, 32, register and datapath width (even, >= IMM_W)
NUM_REGS, 8, number of registers (power of two, >= 2)
SEL_W, $clog2(NUM_REGS)+1, selector width; MSB set = "no register"
IMM_W, 16, immediate width from decoder
PC_IDX, NUM_REGS-1, index of the register used as PC
PC_STEP, 4, PC increment amount
BYPASS, 0, 1 = read ports forward data being written this cycle

Ports:
clk  in  1  system clock, rising edge
rst_b  in  1  synchronous active-low reset
alu_out  in  DATA_W  ALU result write source
dib  in  DATA_W  memory data-in write source
id_imme  in  IMM_W  decoder immediate
alu_a_sel  in  SEL_W  read port A select
alu_b_sel  in  SEL_W  read port B select
addr_sel  in  SEL_W  address port select
dob_sel  in  SEL_W  data-out port select
rtr_sel  in  SEL_W  register-to-register source select
hl_sel  in  2  00 full word, 01 low half, 10 high half, 11 = 00
ip_sel  in  3  write source: 000 none, 001 reg[rtr_sel], 010 alu_out, 011 dib, 100 imm zero-ext, 101 imm sign-ext, 11x none
ip_reg_sel  in  SEL_W  write destination
reg_clr_sel  in  SEL_W  clear destination
reg_wr  in  1  write request (level, held until ack)
reg_clr  in  1  clear strobe
pc_incr  in  1  PC increment strobe
alu_a  out  DATA_W  reg[alu_a_sel]
alu_b  out  DATA_W  reg[alu_b_sel]
addr_out  out  DATA_W  reg[addr_sel]
dob  out  DATA_W  reg[dob_sel]
reg_wr_ack  out  1  write acknowledge, one-cycle pulse

Behaviour:
- Reset (rst_b low at a rising edge):
  - all registers cleared to 0
  - FSM to IDLE, reg_wr_ack = 0
  - read outputs therefore 0
  - reset takes priority over every other event, including a write in flight.
- Selectors: an index is valid iff MSB = 0 and value < NUM_REGS.
  - An invalid read select returns 0.
  - An invalid write or clear destination leaves the registers unchanged; the write is still acknowledged.
- Reads: combinational from the register array.
  - BYPASS=0: the new value is visible the cycle after the committing edge.
  - BYPASS=1: a write committing this cycle to the same index appears on the port in the same cycle.
- Write source (S):
  - Immediate is zero- or sign-extended from IMM_W to DATA_W.
  - ip_sel none: no register modified, still acknowledged.
- hl_sel, with H = DATA_W/2:
  - 00: reg <= S
  - 01: reg[H-1:0] <= S[H-1:0], upper half kept
  - 10: reg[DATA_W-1:H] <= S[H-1:0], lower half kept
- Write FSM (Moore ack):
  - IDLE: reg_wr=1 at an edge -> write committed at that edge, go to ACK.
  - ACK: reg_wr_ack=1 for exactly this cycle. Next edge: reg_wr=0 -> IDLE, else WAIT_LOW.
  - WAIT_LOW: ack=0, no write accepted; reg_wr=0 -> IDLE.
  - Exactly one commit per request regardless of how long reg_wr is held.
  - Latency: request edge to ack visible = 1 cycle.
- Clear: reg_clr=1 at an edge zeroes reg[reg_clr_sel]. Accepted in any FSM state, no handshake.
- PC: pc_incr=1 at an edge -> reg[PC_IDX] += PC_STEP, modulo 2^DATA_W (wraps).
- Same-edge conflicts on one register, priority highest first: reset > clear > write > pc_incr.
  - The losing write is still acknowledged.
  - Events on different registers all take effect at the same edge.
- rtr source reads the pre-edge value, so a self-copy is a no-op.

Decomposition:
- Package reg_bank_pkg:
  - ip_sel encodings (IP_NONE, IP_RTR, IP_ALU, IP_DIB, IP_IMM_Z, IP_IMM_S)
  - hl_sel encodings (HL_FULL, HL_LOW, HL_HIGH)
  - FSM state type (WR_IDLE, WR_ACK, WR_WAIT_LOW)
  - a sel_valid helper function
- Sub-module reg_bank_wr_ctrl: the handshake FSM.
  - Inputs: clk, rst_b, reg_wr.
  - Outputs: wr_commit, reg_wr_ack.
  - Array, muxes and extension logic stay in the top.

Test Plan:
- Reset pulse, then alu_a_sel=0, alu_b_sel=5 -> alu_a=alu_b=0, reg_wr_ack=0.
- ip_sel=010, ip_reg_sel=0, alu_out=AAAAAAAA, reg_wr held 1 cycle -> ack high exactly 1 cycle after request, reg0=AAAAAAAA.
- reg_wr held 5 cycles with dib=BBBBBBBB to reg1 -> ack pulses once, one commit; changing dib to 11111111 mid-hold leaves reg1=BBBBBBBB.
- Immediates:
  - id_imme=CCCC, ip_sel=101, hl_sel=00, reg2 -> reg2=FFFFCCCC.
  - Then ip_sel=100, hl_sel=10, id_imme=1234 -> reg2=1234CCCC.
- PC wrap: reg7=FFFFFFFC, pc_incr=1 -> reg7=00000000. Then reg_clr and reg_wr to reg7 on the same edge -> reg7=0, ack still pulses.
- rst_b low while FSM in ACK -> next cycle ack=0, all reads 0. A new request after reset is accepted normally.
